// File: rtl/mem_parity_responder_if.sv
// Request/response bundle between the test side (master) and the parity responder (slave).
interface mem_parity_responder_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned CNT_W  = 16
) ();
   logic              read;
   logic              write;
   logic [7:0]        data_in;
   logic [ADDR_W-1:0] address;
   logic              parity;
   logic [8:0]        data_out;
   logic              rd_valid;
   logic              ready;
   logic              parity_err;
   logic              rw_err;
   logic [CNT_W-1:0]  rw_err_cnt;

   modport master (
      output read, write, data_in, address, parity,
      input  data_out, rd_valid, ready, parity_err, rw_err, rw_err_cnt
   );

   modport slave (
      input  read, write, data_in, address, parity,
      output data_out, rd_valid, ready, parity_err, rw_err, rw_err_cnt
   );
endinterface

// File: rtl/mem_parity_responder.sv
// Parity-protected byte memory responder: clears itself after reset, serves 1-cycle
// pipelined reads, checks parity on every read and counts read/write collisions.
module mem_parity_responder #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mem_parity_responder_if.slave   bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned WORD_W = 9;

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;

   logic [WORD_W-1:0]   mem_q [DEPTH];
   logic                mem_we_c;
   logic [ADDR_W-1:0]   mem_waddr_c;
   logic [WORD_W-1:0]   mem_wdata_c;
   logic [WORD_W-1:0]   rdata_c;
   logic                rd_en_c;
   logic                coll_c;

   logic [WORD_W-1:0]   data_out_q, data_out_d;
   logic                rd_valid_q, rd_valid_d;
   logic                ready_q, ready_d;
   logic                parity_err_q, parity_err_d;
   logic                rw_err_q, rw_err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next state: sweep every address once, then stay in RUN until reset
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_INIT: begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == '1) state_d = ST_RUN;
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   assign rdata_c = mem_q[bus.address];

   // Outputs: request decode and next values of the registered outputs
   always_comb begin
      mem_we_c     = 1'b0;
      mem_waddr_c  = ptr_q;
      mem_wdata_c  = '0;
      rd_en_c      = 1'b0;
      coll_c       = 1'b0;
      case (state_q)
         ST_INIT: mem_we_c = 1'b1;
         ST_RUN: begin
            // ready_q gates acceptance so nothing is taken before ready is visible
            if (ready_q) begin
               if (bus.read && bus.write) begin
                  coll_c = 1'b1;
               end else if (bus.write) begin
                  mem_we_c    = 1'b1;
                  mem_waddr_c = bus.address;
                  mem_wdata_c = {(^bus.data_in) ^ bus.parity, bus.data_in};
               end else if (bus.read) begin
                  rd_en_c = 1'b1;
               end
            end
         end
         default: mem_we_c = 1'b0;
      endcase

      ready_d      = (state_q == ST_RUN);
      rd_valid_d   = rd_en_c;
      data_out_d   = rd_en_c ? rdata_c : data_out_q;
      parity_err_d = rd_en_c && ((^rdata_c[7:0]) != rdata_c[8]);
      rw_err_d     = coll_c;
      cnt_d        = (coll_c && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // Storage array is not reset; the INIT sweep clears it
   always_ff @(posedge clk) begin
      if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q   <= '0;
         rd_valid_q   <= 1'b0;
         ready_q      <= 1'b0;
         parity_err_q <= 1'b0;
         rw_err_q     <= 1'b0;
         cnt_q        <= '0;
      end else begin
         data_out_q   <= data_out_d;
         rd_valid_q   <= rd_valid_d;
         ready_q      <= ready_d;
         parity_err_q <= parity_err_d;
         rw_err_q     <= rw_err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.ready      = ready_q;
   assign bus.parity_err = parity_err_q;
   assign bus.rw_err     = rw_err_q;
   assign bus.rw_err_cnt = cnt_q;
endmodule

// File: tb/tb_mem_parity_responder.sv
// Self-checking bench for mem_parity_responder: directed scenarios plus random traffic
// against a simple array/counter model of the memory.
module tb_mem_parity_responder;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned CNT_W  = 2;
   localparam int DEPTH   = 16;
   localparam int CNT_MAX = 3;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   mem_parity_responder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   mem_parity_responder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model
   logic [8:0] mdl [DEPTH];
   int         mdl_cnt;
   logic [8:0] exp_dout;
   logic       exp_rv;
   logic       exp_pe;
   logic       exp_rw;

   function automatic logic odd_ones(input logic [7:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mdl[i] = 9'h000;
      mdl_cnt  = 0;
      exp_dout = 9'h000;
      exp_rv   = 1'b0;
      exp_pe   = 1'b0;
      exp_rw   = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request for one edge and advance the model accordingly
   task automatic step(input logic rd, input logic wr, input int a,
                       input logic [7:0] d, input logic p);
      bus.read    = rd;
      bus.write   = wr;
      bus.address = 4'(a);
      bus.data_in = d;
      bus.parity  = p;
      tick();
      bus.read  = 1'b0;
      bus.write = 1'b0;
      bus.parity = 1'b0;
      exp_rv = rd && !wr;
      exp_rw = rd && wr;
      exp_pe = 1'b0;
      if (exp_rv) begin
         exp_dout = mdl[a % DEPTH];
         exp_pe   = odd_ones(exp_dout[7:0]) != exp_dout[8];
      end
      if (wr && !rd) mdl[a % DEPTH] = {odd_ones(d) ^ p, d};
      if (exp_rw && mdl_cnt < CNT_MAX) mdl_cnt++;
   endtask

   task automatic test_reset();
      int rise_edge;
      bus.read = 1'b0; bus.write = 1'b0; bus.data_in = '0;
      bus.address = '0; bus.parity = 1'b0;
      rst_n = 1'b0;
      model_reset();
      tick(); tick();
      total++; if (bus.data_out !== 9'h000) begin bad++; $display("FAIL reset_data_out got=%h exp=000", bus.data_out); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
      total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
      total++; if (bus.parity_err !== 1'b0 || bus.rw_err !== 1'b0) begin bad++; $display("FAIL reset_errs got=%b%b exp=00", bus.parity_err, bus.rw_err); end
      total++; if (bus.rw_err_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.rw_err_cnt); end
      rst_n = 1'b1;
      rise_edge = 0;
      for (int e = 1; e <= 40 && rise_edge == 0; e++) begin
         tick();
         // Strobes during the sweep must be ignored
         bus.read = 1'b1; bus.write = (e % 2 == 0); bus.address = 4'(e); bus.data_in = 8'hFF;
         if (bus.ready === 1'b1) rise_edge = e;
      end
      bus.read = 1'b0; bus.write = 1'b0;
      total++; if (rise_edge != DEPTH + 1) begin bad++; $display("FAIL ready_rise_edge got=%0d exp=%0d", rise_edge, DEPTH + 1); end
      total++; if (bus.rd_valid !== 1'b0 || bus.rw_err !== 1'b0 || bus.rw_err_cnt !== 2'd0) begin
         bad++; $display("FAIL init_ignores_strobes got rv=%b rw=%b cnt=%0d exp 0 0 0", bus.rd_valid, bus.rw_err, bus.rw_err_cnt);
      end
   endtask

   task automatic test_sweep_clear();
      // Back-to-back reads of every address, one result per cycle
      for (int a = 0; a < DEPTH; a++) begin
         step(1'b1, 1'b0, a, 8'h00, 1'b0);
         total++;
         if (bus.rd_valid !== 1'b1 || bus.data_out !== 9'h000 || bus.parity_err !== 1'b0) begin
            bad++; $display("FAIL sweep_read a=%0d got rv=%b d=%h pe=%b exp 1 000 0", a, bus.rd_valid, bus.data_out, bus.parity_err);
         end
      end
      tick();
      total++; if (bus.rd_valid !== 1'b0 || bus.data_out !== 9'h000) begin
         bad++; $display("FAIL sweep_idle got rv=%b d=%h exp 0 000", bus.rd_valid, bus.data_out);
      end
   endtask

   task automatic test_write_read();
      step(1'b0, 1'b1, 3, 8'hA5, 1'b0);
      step(1'b1, 1'b0, 3, 8'h00, 1'b0);
      total++; if (bus.rd_valid !== 1'b1 || bus.data_out !== 9'h0A5 || bus.parity_err !== 1'b0) begin
         bad++; $display("FAIL wr_rd_A5 got rv=%b d=%h pe=%b exp 1 0a5 0", bus.rd_valid, bus.data_out, bus.parity_err);
      end
      step(1'b0, 1'b1, 4, 8'h07, 1'b0);
      total++; if (bus.rd_valid !== 1'b0 || bus.data_out !== 9'h0A5) begin
         bad++; $display("FAIL hold_data_out got rv=%b d=%h exp 0 0a5", bus.rd_valid, bus.data_out);
      end
      step(1'b1, 1'b0, 4, 8'h00, 1'b0);
      total++; if (bus.data_out !== 9'h107 || bus.parity_err !== 1'b0) begin
         bad++; $display("FAIL wr_rd_07 got d=%h pe=%b exp 107 0", bus.data_out, bus.parity_err);
      end
   endtask

   task automatic test_parity_inject();
      step(1'b0, 1'b1, 5, 8'h07, 1'b1);
      step(1'b1, 1'b0, 5, 8'h00, 1'b0);
      total++; if (bus.data_out !== 9'h007 || bus.parity_err !== 1'b1 || bus.rd_valid !== 1'b1) begin
         bad++; $display("FAIL inject_read got d=%h pe=%b rv=%b exp 007 1 1", bus.data_out, bus.parity_err, bus.rd_valid);
      end
      tick();
      total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL inject_pulse_width got=%b exp=0", bus.parity_err); end
      step(1'b0, 1'b1, 5, 8'h07, 1'b0);
      step(1'b1, 1'b0, 5, 8'h00, 1'b0);
      total++; if (bus.data_out !== 9'h107 || bus.parity_err !== 1'b0) begin
         bad++; $display("FAIL inject_cleared got d=%h pe=%b exp 107 0", bus.data_out, bus.parity_err);
      end
   endtask

   task automatic test_collision();
      step(1'b1, 1'b1, 3, 8'hFF, 1'b0);
      total++; if (bus.rw_err !== 1'b1 || bus.rw_err_cnt !== 2'd1 || bus.rd_valid !== 1'b0) begin
         bad++; $display("FAIL collision got rw=%b cnt=%0d rv=%b exp 1 1 0", bus.rw_err, bus.rw_err_cnt, bus.rd_valid);
      end
      tick();
      total++; if (bus.rw_err !== 1'b0) begin bad++; $display("FAIL collision_pulse got=%b exp=0", bus.rw_err); end
      step(1'b1, 1'b0, 3, 8'h00, 1'b0);
      total++; if (bus.data_out !== 9'h0A5) begin bad++; $display("FAIL collision_no_write got=%h exp=0a5", bus.data_out); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
         step(1'b1, 1'b1, i, 8'(i), 1'b0);
         total++; if (bus.rw_err !== 1'b1 || int'(bus.rw_err_cnt) != mdl_cnt) begin
            bad++; $display("FAIL sat_cnt i=%0d got rw=%b cnt=%0d exp 1 %0d", i, bus.rw_err, bus.rw_err_cnt, mdl_cnt);
         end
      end
      total++; if (bus.rw_err_cnt !== 2'd3) begin bad++; $display("FAIL sat_final got=%0d exp=3", bus.rw_err_cnt); end
   endtask

   task automatic test_random();
      logic rd, wr, p;
      int   a;
      logic [7:0] d;
      for (int i = 0; i < 300; i++) begin
         rd = ($urandom_range(0, 99) < 45);
         wr = ($urandom_range(0, 99) < 45);
         p  = ($urandom_range(0, 99) < 20);
         a  = int'($urandom_range(0, DEPTH - 1));
         d  = 8'($urandom);
         step(rd, wr, a, d, p);
         total++;
         if (bus.rd_valid !== exp_rv || bus.data_out !== exp_dout || bus.parity_err !== exp_pe ||
             bus.rw_err !== exp_rw || int'(bus.rw_err_cnt) != mdl_cnt) begin
            bad++;
            $display("FAIL random i=%0d got rv=%b d=%h pe=%b rw=%b cnt=%0d exp %b %h %b %b %0d",
                     i, bus.rd_valid, bus.data_out, bus.parity_err, bus.rw_err, bus.rw_err_cnt,
                     exp_rv, exp_dout, exp_pe, exp_rw, mdl_cnt);
         end
      end
   endtask

   task automatic test_reset_midread();
      int waited;
      step(1'b0, 1'b1, 3, 8'h5A, 1'b0);
      bus.read = 1'b1; bus.address = 4'd3;
      #2;
      rst_n = 1'b0;
      #1;
      bus.read = 1'b0;
      model_reset();
      total++; if (bus.rd_valid !== 1'b0 || bus.data_out !== 9'h000 || bus.rw_err_cnt !== 2'd0) begin
         bad++; $display("FAIL midread_reset got rv=%b d=%h cnt=%0d exp 0 000 0", bus.rd_valid, bus.data_out, bus.rw_err_cnt);
      end
      tick();
      total++; if (bus.rd_valid !== 1'b0 || bus.data_out !== 9'h000) begin
         bad++; $display("FAIL midread_cancel got rv=%b d=%h exp 0 000", bus.rd_valid, bus.data_out);
      end
      rst_n = 1'b1;
      waited = 0;
      while (bus.ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      total++; if (waited != DEPTH + 1) begin bad++; $display("FAIL midread_reinit_cycles got=%0d exp=%0d", waited, DEPTH + 1); end
      step(1'b1, 1'b0, 3, 8'h00, 1'b0);
      total++; if (bus.rd_valid !== 1'b1 || bus.data_out !== 9'h000 || bus.parity_err !== 1'b0) begin
         bad++; $display("FAIL midread_cleared got rv=%b d=%h pe=%b exp 1 000 0", bus.rd_valid, bus.data_out, bus.parity_err);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      #1;
      test_reset();
      test_sweep_clear();
      test_write_read();
      test_parity_inject();
      test_collision();
      test_saturation();
      test_random();
      test_reset_midread();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
